inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Upstream neighbour of the opcode decoder in the MIPS single-cycle core. Owns the PC and fetches from instruction memory with a req/ready handshake.
- Holds the fetched word stable for the decode/execute cycle and presents Inst_31_26 to the control decoder.
- Computes the next PC from the decoder's Branch/Branch_Not_Equal/Jump outputs and the ALU Zero flag. Supplies PC_Plus_4 for the jal link write.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_LAT_MAX, 16, maximum cycles Imem_Ready may stay low before Fetch_Timeout pulses.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Imem_Req  output  1  fetch request to instruction memory.
- Imem_Addr  output  32  word-aligned fetch address; bits [1:0] are always 2'b00.
- Imem_Ready  input  1  memory has Imem_Rdata valid this cycle.
- Imem_Rdata  input  32  fetched instruction word.
- Branch  input  1  from control decoder (beq).
- Branch_Not_Equal  input  1  from control decoder (bne).
- Jump  input  1  from control decoder (j/jal).
- Zero  input  1  ALU equality flag.
- Branch_Offset  input  32  sign-extended immediate, in words.
- Stall  input  1  hold the current instruction for another cycle.
- Inst  output  32  held instruction word.
- Inst_31_26  output  6  equals Inst[31:26]; feeds the control decoder.
- Inst_Valid  output  1  Inst is a real fetched instruction; downstream gates Reg_Write and Mem_Write with it.
- PC  output  32  address of Inst.
- PC_Plus_4  output  32  PC+4, wrapping mod 2^32.
- Fetch_Timeout  output  1  one-cycle pulse when the ready-wait counter reaches IMEM_LAT_MAX.

Behaviour:
- Reset (Rst_n=0, takes effect immediately regardless of state):
  - PC=RESET_PC, Inst=32'h0, Inst_Valid=0, Imem_Req=0, wait counter=0, Fetch_Timeout=0, state=IDLE.
  - Reset asserted mid-fetch abandons the request; a late Imem_Ready is ignored.
- FSM states IDLE, REQ, HOLD.
- IDLE:
  - Lasts exactly one cycle after reset release, then goes to REQ.
  - Imem_Req=0; Imem_Ready is ignored.
- REQ:
  - Imem_Req=1 and Imem_Addr={PC[31:2],2'b00}, both stable until Imem_Ready.
  - On Imem_Ready=1: Inst<=Imem_Rdata, Inst_Valid<=1, go to HOLD. Minimum fetch latency is one cycle (Ready in the first REQ cycle).
  - While Ready=0: wait counter increments. When it reaches IMEM_LAT_MAX, Fetch_Timeout pulses for one cycle, the counter clears, and the request remains asserted (no abort).
  - Stall is ignored in REQ.
- HOLD:
  - Imem_Req=0; Inst, PC and Inst_Valid are held.
  - Stall=1: remain in HOLD with all state unchanged.
  - Stall=0: PC<=next_pc, Inst_Valid<=0, go to REQ. Inst keeps its old value but is invalid.
- next_pc, evaluated only in the HOLD cycle with Stall=0. Priority is Jump > taken branch > sequential:
  - Jump=1: {PC_Plus_4[31:28], Inst[25:0], 2'b00}.
  - Else if (Branch & Zero) | (Branch_Not_Equal & ~Zero): PC_Plus_4 + (Branch_Offset<<2), 32-bit modular arithmetic.
  - Else: PC_Plus_4.
  - Branch and Branch_Not_Equal both asserted: either condition alone takes the branch.
  - X on control inputs while Inst_Valid=0 has no effect.
- Arithmetic and output rules:
  - PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
  - A computed target with bits [1:0]≠0 cannot occur (shift by 2); PC[1:0] is forced to 0.
  - Inst_31_26 and PC_Plus_4 are combinational from registers; no input-to-output combinational path.

Test Plan:
- Reset release, Imem_Ready=1 every cycle, Rdata=32'h2008_0005 (addi), Stall=0, decoder inputs 0 -> Imem_Addr sequence 0,4,8; Inst_31_26=6'd8; Inst_Valid pulses 1 every 2nd cycle.
- In HOLD with PC=32'h40, Inst=32'h0800_0010 (j), Jump=1 -> next Imem_Addr=32'h40; with PC=32'h100 and the same Inst -> Imem_Addr=32'h0000_0040 (upper nibble from PC_Plus_4).
- PC=32'h20, Branch_Offset=32'hFFFF_FFFE, Branch_Not_Equal=1, Zero=0 -> Imem_Addr=32'h1C. Same with Zero=1 -> 32'h24.
- Imem_Ready held low for 20 cycles with IMEM_LAT_MAX=16 -> Fetch_Timeout pulses once at cycle 16, Imem_Addr stable throughout, Inst captured when Ready arrives.
- Stall=1 for 3 cycles in HOLD -> Inst, PC and Inst_Valid=1 unchanged, Imem_Req=0, PC advances only after Stall drops.
- Rst_n pulsed low while in REQ waiting for Ready -> immediately Imem_Req=0, Inst_Valid=0, PC=RESET_PC; Ready arriving during reset is ignored; fetch restarts at RESET_PC after one IDLE cycle.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over a req/ready port and
// holds the word for decode while computing jump/branch targets.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_LAT_MAX = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  input  logic        Branch,
  input  logic        Branch_Not_Equal,
  input  logic        Jump,
  input  logic        Zero,
  input  logic [31:0] Branch_Offset,
  input  logic        Stall,
  output logic [31:0] Inst,
  output logic [5:0]  Inst_31_26,
  output logic        Inst_Valid,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus_4,
  output logic        Fetch_Timeout
);

  localparam int CW = $clog2(IMEM_LAT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_LAT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   inst, inst_nxt;
  logic          valid, valid_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tmo, tmo_nxt;

  logic [31:0] pc_plus_4;
  logic [31:0] jump_target;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        taken;

  assign pc_plus_4   = pc + 32'd4;
  assign jump_target = {pc_plus_4[31:28], inst[25:0], 2'b00};
  assign br_target   = pc_plus_4 + (Branch_Offset << 2);
  assign taken       = (Branch & Zero) | (Branch_Not_Equal & ~Zero);

  // Jump wins over a taken branch.
  always_comb begin
    next_pc = pc_plus_4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (taken) begin
      next_pc = br_target;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst;
    valid_nxt = valid;
    cnt_nxt   = '0;
    tmo_nxt   = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (Imem_Ready) begin
          inst_nxt  = Imem_Rdata;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end else if (cnt == CNT_LAST) begin
          // Flag the slow memory but keep requesting.
          tmo_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (!Stall) begin
          pc_nxt    = {next_pc[31:2], 2'b00};
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      pc    <= {RESET_PC[31:2], 2'b00};
      inst  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      inst  <= inst_nxt;
      valid <= valid_nxt;
      cnt   <= cnt_nxt;
      tmo   <= tmo_nxt;
    end
  end

  assign Imem_Req      = (state == REQ);
  assign Imem_Addr     = {pc[31:2], 2'b00};
  assign Inst          = inst;
  assign Inst_31_26    = inst[31:26];
  assign Inst_Valid    = valid;
  assign PC            = pc;
  assign PC_Plus_4     = pc_plus_4;
  assign Fetch_Timeout = tmo;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed fetch sequence with
// jumps, branches, stalls, memory wait/timeout and mid-fetch reset.
module tb_inst_fetch_unit;

  localparam int LAT = 16;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ready;
  logic [31:0] Imem_Rdata;
  logic        Branch;
  logic        Branch_Not_Equal;
  logic        Jump;
  logic        Zero;
  logic [31:0] Branch_Offset;
  logic        Stall;
  logic [31:0] Inst;
  logic [5:0]  Inst_31_26;
  logic        Inst_Valid;
  logic [31:0] PC;
  logic [31:0] PC_Plus_4;
  logic        Fetch_Timeout;

  inst_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_LAT_MAX(LAT)
  ) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .Imem_Req        (Imem_Req),
    .Imem_Addr       (Imem_Addr),
    .Imem_Ready      (Imem_Ready),
    .Imem_Rdata      (Imem_Rdata),
    .Branch          (Branch),
    .Branch_Not_Equal(Branch_Not_Equal),
    .Jump            (Jump),
    .Zero            (Zero),
    .Branch_Offset   (Branch_Offset),
    .Stall           (Stall),
    .Inst            (Inst),
    .Inst_31_26      (Inst_31_26),
    .Inst_Valid      (Inst_Valid),
    .PC              (PC),
    .PC_Plus_4       (PC_Plus_4),
    .Fetch_Timeout   (Fetch_Timeout)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_hold[$];
  logic        prev_valid = 1'b0;

  localparam logic [31:0] ADDI = 32'h2008_0005;
  localparam logic [31:0] J10  = 32'h0800_0010;
  localparam logic [31:0] J40  = 32'h0800_0040;
  localparam logic [31:0] J08  = 32'h0800_0008;
  localparam logic [31:0] BNE  = 32'h1400_FFFE;

  function automatic void chk(string name, logic [127:0] act,
                              logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge Clk) begin
    if (Rst_n && Imem_Req && Imem_Ready) begin
      if (exp_addr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL fetch_addr: unexpected fetch at %h", Imem_Addr);
      end else begin
        chk("fetch_addr", Imem_Addr, exp_addr.pop_front());
      end
    end
    if (Rst_n && Inst_Valid && !prev_valid) begin
      if (exp_hold.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL hold: unexpected valid inst %h", Inst);
      end else begin
        logic [63:0] e;
        e = exp_hold.pop_front();
        chk("hold", {PC, Inst, Inst_31_26, PC_Plus_4},
            {e[63:32], e[31:0], e[31:26], e[63:32] + 32'd4});
      end
    end
    prev_valid <= Rst_n && Inst_Valid;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Called in a REQ cycle; returns in the following REQ cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input logic j, input logic b,
                       input logic bn, input logic z,
                       input logic [31:0] off,
                       input int waitc, input int stallc);
    int pulses;
    pulses = 0;
    Imem_Rdata = 32'hDEAD_BEEF;
    if (waitc > 0) begin
      Imem_Ready = 1'b0;
      for (int i = 0; i < waitc; i++) begin
        @(negedge Clk);
        chk("wait", {Imem_Req, Imem_Addr, Fetch_Timeout},
            {1'b1, a, (i > 0) && (i % LAT == 0)});
        if (Fetch_Timeout) pulses++;
        step();
      end
      chk("timeout_count", pulses, (waitc - 1) / LAT);
    end
    Imem_Ready = 1'b1;
    Imem_Rdata = d;
    exp_addr.push_back(a);
    exp_hold.push_back({a, d});
    step();
    Imem_Rdata = 32'hDEAD_BEEF;
    Jump = j;
    Branch = b;
    Branch_Not_Equal = bn;
    Zero = z;
    Branch_Offset = off;
    Stall = (stallc > 0);
    for (int i = 0; i < stallc; i++) begin
      @(negedge Clk);
      chk("stall", {Imem_Req, Inst_Valid, PC, Inst}, {1'b0, 1'b1, a, d});
      step();
    end
    Stall = 1'b0;
    step();
    Jump = 1'b0;
    Branch = 1'b0;
    Branch_Not_Equal = 1'b0;
    Zero = 1'b0;
    Branch_Offset = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b0;
    Imem_Ready = 1'b0;
    Imem_Rdata = '0;
    Branch = 1'b0;
    Branch_Not_Equal = 1'b0;
    Jump = 1'b0;
    Zero = 1'b0;
    Branch_Offset = '0;
    Stall = 1'b0;
    step();
    @(negedge Clk);
    chk("reset", {Imem_Req, Inst_Valid, PC, Inst, Fetch_Timeout, PC_Plus_4},
        {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4});
    step();
    Rst_n = 1'b1;
    Imem_Ready = 1'b1;
    @(negedge Clk);
    chk("idle", {Imem_Req, Inst_Valid}, {1'b0, 1'b0});
    step();

    fetch(32'h0,  ADDI, 0, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h4,  ADDI, 0, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h8,  ADDI, 0, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'hC,  J10,  1, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h40, J10,  1, 0, 0, 0, 32'h0, 0, 3);
    fetch(32'h40, J40,  1, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h100, J10, 1, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h40, J08,  1, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h20, BNE,  0, 0, 1, 0, 32'hFFFF_FFFE, 0, 0);
    fetch(32'h1C, J08,  1, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h20, BNE,  0, 0, 1, 1, 32'hFFFF_FFFE, 0, 0);
    fetch(32'h24, 32'h1000_0003, 0, 1, 0, 1, 32'h3, 0, 0);
    fetch(32'h34, 32'h1400_0001, 0, 1, 1, 0, 32'h1, 0, 0);
    fetch(32'h3C, J08,  1, 1, 0, 1, 32'h100, 0, 0);
    fetch(32'h20, 32'h1000_0000, 0, 1, 0, 1, 32'h03FF_FFF7, 0, 0);
    fetch(32'h1000_0000, J10, 1, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h1000_0040, 32'h1000_0000, 0, 1, 0, 1,
          32'hFBFF_FFF7, 0, 0);
    fetch(32'h20, 32'h1000_FFF6, 0, 1, 0, 1, 32'hFFFF_FFF6, 0, 0);
    fetch(32'hFFFF_FFFC, ADDI, 0, 0, 0, 0, 32'h0, 20, 0);
    fetch(32'h0, ADDI, 0, 1, 0, 0, 32'h5, 0, 0);

    Imem_Ready = 1'b0;
    step();
    step();
    Rst_n = 1'b0;
    #1;
    chk("reset_abort", {Imem_Req, Inst_Valid, PC, Inst, Fetch_Timeout},
        {1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    Imem_Ready = 1'b1;
    Imem_Rdata = 32'h1234_5678;
    step();
    @(negedge Clk);
    chk("reset_ready", {Imem_Req, Inst_Valid, Inst}, {1'b0, 1'b0, 32'h0});
    step();
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("idle_after_reset", {Imem_Req, Inst_Valid}, {1'b0, 1'b0});
    step();
    fetch(32'h0, ADDI, 0, 0, 0, 0, 32'h0, 0, 0);
    fetch(32'h4, ADDI, 0, 0, 0, 0, 32'h0, 0, 0);

    Imem_Ready = 1'b0;
    step();
    step();
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("hold_queue_empty", exp_hold.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
